// File: rtl/axi_ic_pkg.sv
// Shared definitions for the 4-master AXI3 interconnect.
// Tag/ID/response widths and the B-response FIFO entry layout.
package axi_ic_pkg;

  localparam int MTAG_W = 2;
  localparam int MID_W  = 4;
  localparam int SID_W  = 6;
  localparam int RESP_W = 2;

  typedef enum logic [MTAG_W-1:0] {
    MTAG_M1 = 2'd0,
    MTAG_M2 = 2'd1,
    MTAG_M3 = 2'd2,
    MTAG_M4 = 2'd3
  } mtag_e;

  typedef enum logic [RESP_W-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } bresp_e;

  typedef struct packed {
    logic [MTAG_W-1:0] tag;
    logic [MID_W-1:0]  id;
    logic [RESP_W-1:0] resp;
  } bent_t;

  localparam int BENT_W = $bits(bent_t);

endpackage

// File: rtl/wresp_demux_m4_if.sv
// B-channel bundle: one slave-side port and four master-side ports.
// The slave modport is the demux view; master is the environment view.
interface wresp_demux_m4_if;
  import axi_ic_pkg::*;

  logic [SID_W-1:0]  bid_s;
  logic [RESP_W-1:0] bresp_s;
  logic              bvalid_s;
  logic              bready_s;

  logic [MID_W-1:0]  bid_m1, bid_m2, bid_m3, bid_m4;
  logic [RESP_W-1:0] bresp_m1, bresp_m2, bresp_m3, bresp_m4;
  logic              bvalid_m1, bvalid_m2, bvalid_m3, bvalid_m4;
  logic              bready_m1, bready_m2, bready_m3, bready_m4;

  modport slave (
    input  bid_s, bresp_s, bvalid_s,
    output bready_s,
    output bid_m1, bid_m2, bid_m3, bid_m4,
    output bresp_m1, bresp_m2, bresp_m3, bresp_m4,
    output bvalid_m1, bvalid_m2, bvalid_m3, bvalid_m4,
    input  bready_m1, bready_m2, bready_m3, bready_m4
  );

  modport master (
    output bid_s, bresp_s, bvalid_s,
    input  bready_s,
    input  bid_m1, bid_m2, bid_m3, bid_m4,
    input  bresp_m1, bresp_m2, bresp_m3, bresp_m4,
    input  bvalid_m1, bvalid_m2, bvalid_m3, bvalid_m4,
    output bready_m1, bready_m2, bready_m3, bready_m4
  );

endinterface

// File: rtl/resp_fifo.sv
// Generic synchronous FIFO, register-array storage.
// Pointers carry an extra wrap bit to tell full from empty.
module resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  logic [W-1:0]   din_i,
  input  logic           pop_i,
  output logic [W-1:0]   dout_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [PTR_W:0] level_o
);

  logic [W-1:0]   mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/wresp_demux_m4.sv
// B-response return path: FIFO plus tag-based routing to 4 masters.
// Optional outstanding-write checker under WRESP_OUTSTANDING_CHK_EN.
module wresp_demux_m4
  import axi_ic_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              aw_hs,
  wresp_demux_m4_if.slave   bus,
`ifdef WRESP_OUTSTANDING_CHK_EN
  output logic              err_unexp_resp,
  output logic [4:0]        outstanding,
`endif
  output logic [PTR_W:0]    fifo_level
);

  logic                    full, empty;
  logic                    push, pop;
  logic [BENT_W-1:0]       wr_ent;
  logic [BENT_W-1:0]       head_raw;
  bent_t                   head;
  logic [3:0]              sel;
  logic [3:0]              rdy;

  assign wr_ent        = {bus.bid_s, bus.bresp_s};
  assign bus.bready_s  = ~full;
  assign push          = bus.bvalid_s & ~full;

  resp_fifo #(
    .W     (BENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (areset),
    .push_i  (push),
    .din_i   (wr_ent),
    .pop_i   (pop),
    .dout_o  (head_raw),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  assign head = bent_t'(head_raw);

  // One-hot master select straight from the FIFO head
  always_comb begin
    sel = '0;
    if (!empty) sel[head.tag] = 1'b1;
  end

  assign rdy = {bus.bready_m4, bus.bready_m3,
                bus.bready_m2, bus.bready_m1};
  assign pop = |(sel & rdy);

  assign bus.bvalid_m1 = sel[0];
  assign bus.bvalid_m2 = sel[1];
  assign bus.bvalid_m3 = sel[2];
  assign bus.bvalid_m4 = sel[3];

  assign bus.bid_m1   = sel[0] ? head.id   : '0;
  assign bus.bid_m2   = sel[1] ? head.id   : '0;
  assign bus.bid_m3   = sel[2] ? head.id   : '0;
  assign bus.bid_m4   = sel[3] ? head.id   : '0;
  assign bus.bresp_m1 = sel[0] ? head.resp : '0;
  assign bus.bresp_m2 = sel[1] ? head.resp : '0;
  assign bus.bresp_m3 = sel[2] ? head.resp : '0;
  assign bus.bresp_m4 = sel[3] ? head.resp : '0;

`ifdef WRESP_OUTSTANDING_CHK_EN
  logic [4:0] outst_q, outst_d;
  logic       err_q, err_d;

  // Saturating count of AW accepted minus B returned
  always_comb begin
    outst_d = outst_q;
    if (aw_hs && !push && outst_q != 5'd31)
      outst_d = outst_q + 5'd1;
    else if (push && !aw_hs && outst_q != 5'd0)
      outst_d = outst_q - 5'd1;
    err_d = err_q | (push & ~aw_hs & (outst_q == 5'd0));
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  assign outstanding    = outst_q;
  assign err_unexp_resp = err_q;
`else
  logic unused_aw_hs;
  assign unused_aw_hs = aw_hs;
`endif

endmodule
